// File: rtl/fault_map_collector.sv
// fault_map_collector
// Collects per-PE mismatch flags over one test session into a sticky fault map.
// It classifies each row and column against a threshold and streams the map
// into the eNVM write port one row per cycle.
// Optional macro FAULT_COUNT_EN adds a registered total_fault_count output,
// which holds the popcount of the whole map.
module fault_map_collector #(
   parameter int SYSTOLIC_SIZE = 8,
   parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE),
   parameter int ROW_THRESHOLD = 2,
   parameter int COL_THRESHOLD = 2,
   parameter int CNT_WIDTH     = $clog2(SYSTOLIC_SIZE*SYSTOLIC_SIZE+1)
)(
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   test_start,
   input  logic                                   compare_valid,
   input  logic [SYSTOLIC_SIZE*SYSTOLIC_SIZE-1:0] pe_fail_flat,
   input  logic                                   test_done,
   output logic                                   detection_en,
   output logic [ADDR_WIDTH-1:0]                  counter,
   output logic [SYSTOLIC_SIZE-1:0]               single_pe_detection,
   output logic                                   row_fault_detection,
   output logic                                   column_fault_detection,
   output logic                                   busy,
   output logic                                   done
`ifdef FAULT_COUNT_EN
   ,
   output logic [CNT_WIDTH-1:0]                   total_fault_count
`endif
);

   typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

   // Row-major map: map[r][c] lines up with pe_fail_flat bit r*SYSTOLIC_SIZE+c.
   typedef logic [SYSTOLIC_SIZE-1:0][SYSTOLIC_SIZE-1:0] map_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(SYSTOLIC_SIZE-1);
   localparam logic [CNT_WIDTH-1:0]  ROW_TH   = CNT_WIDTH'(ROW_THRESHOLD);
   localparam logic [CNT_WIDTH-1:0]  COL_TH   = CNT_WIDTH'(COL_THRESHOLD);

   state_t                state_q, state_d;
   map_t                  map_q, map_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [CNT_WIDTH-1:0]  rowCnt, colCnt;

   // State, map and row pointer registers; reset drops any write-out in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         map_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         map_q   <= map_d;
         ptr_q   <= ptr_d;
      end
   end

   // Next-state logic: a session start always clears the map.
   // In WRITE the pointer walks the rows, and leaving WRITE parks the pointer at 0.
   always_comb begin
      state_d = state_q;
      map_d   = map_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         IDLE: begin
            if (test_start) begin
               state_d = COLLECT;
               map_d   = '0;
            end
         end
         COLLECT: begin
            if (test_start) begin
               map_d = '0;
            end else begin
               if (compare_valid) begin
                  map_d = map_q | map_t'(pe_fail_flat);
               end
               if (test_done) begin
                  state_d = WRITE;
                  ptr_d   = '0;
               end
            end
         end
         WRITE: begin
            if (test_start) begin
               state_d = COLLECT;
               map_d   = '0;
               ptr_d   = '0;
            end else if (ptr_q == LAST_ROW) begin
               state_d = DONE;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + ADDR_WIDTH'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Moore outputs decoded only from the state and pointer registers.
   always_comb begin
      detection_en = (state_q == WRITE);
      busy         = (state_q == COLLECT) || (state_q == WRITE);
      done         = (state_q == DONE);
      counter      = ptr_q;
   end

   // Row and column classification for the row/column the pointer selects.
   always_comb begin
      rowCnt = '0;
      colCnt = '0;
      for (int c = 0; c < SYSTOLIC_SIZE; c++) begin
         rowCnt = rowCnt + CNT_WIDTH'(map_q[ptr_q][c]);
      end
      for (int r = 0; r < SYSTOLIC_SIZE; r++) begin
         colCnt = colCnt + CNT_WIDTH'(map_q[r][ptr_q]);
      end
      single_pe_detection    = map_q[ptr_q];
      row_fault_detection    = (rowCnt >= ROW_TH);
      column_fault_detection = (colCnt >= COL_TH);
   end

`ifdef FAULT_COUNT_EN
   logic [CNT_WIDTH-1:0] mapPop;
   logic [CNT_WIDTH-1:0] count_q;
   logic                 startTaken;

   // The clear happens only when the FSM actually accepts test_start.
   // In DONE, test_start is ignored, so the count is kept there.
   assign startTaken = test_start && (state_q != DONE);

   // Popcount of the whole map feeding the registered total.
   always_comb begin
      mapPop = '0;
      for (int r = 0; r < SYSTOLIC_SIZE; r++) begin
         for (int c = 0; c < SYSTOLIC_SIZE; c++) begin
            mapPop = mapPop + CNT_WIDTH'(map_q[r][c]);
         end
      end
   end

   // Registered total; it trails each map change by one edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (startTaken) begin
         count_q <= '0;
      end else begin
         count_q <= mapPop;
      end
   end

   assign total_fault_count = count_q;
`endif

endmodule

// File: tb/tb_fault_map_collector.sv
// tb_fault_map_collector
// Scoreboard bench for fault_map_collector. The expected write-out rows are
// queued from a bench-side fault map when test_done is driven. A negedge
// monitor pops and compares those rows. Each scenario task also checks
// latency, done timing and corner values inline.
module tb_fault_map_collector;

   localparam int SS = 8;
   localparam int AW = 3;
   localparam int CW = 7;
   localparam int ROW_TH = 2;
   localparam int COL_TH = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             test_start = 1'b0;
   logic             compare_valid = 1'b0;
   logic [SS*SS-1:0] pe_fail_flat = '0;
   logic             test_done = 1'b0;
   logic             detection_en;
   logic [AW-1:0]    counter;
   logic [SS-1:0]    single_pe_detection;
   logic             row_fault_detection;
   logic             column_fault_detection;
   logic             busy;
   logic             done;
`ifdef FAULT_COUNT_EN
   logic [CW-1:0]    total_fault_count;
`endif

   fault_map_collector dut (
      .clk                    (clk),
      .rst                    (rst),
      .test_start             (test_start),
      .compare_valid          (compare_valid),
      .pe_fail_flat           (pe_fail_flat),
      .test_done              (test_done),
      .detection_en           (detection_en),
      .counter                (counter),
      .single_pe_detection    (single_pe_detection),
      .row_fault_detection    (row_fault_detection),
      .column_fault_detection (column_fault_detection),
      .busy                   (busy),
      .done                   (done)
`ifdef FAULT_COUNT_EN
      ,
      .total_fault_count      (total_fault_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] cnt;
      logic [SS-1:0] row;
      logic          rf;
      logic          cf;
   } exp_t;

   exp_t             sbq[$];
   logic [SS*SS-1:0] modelMap = '0;
   int               checks = 0;
   int               failures = 0;

   function automatic int rowPop(input int r);
      int n = 0;
      for (int c = 0; c < SS; c++) n += int'(modelMap[r*SS+c]);
      return n;
   endfunction

   function automatic int colPop(input int c);
      int n = 0;
      for (int r = 0; r < SS; r++) n += int'(modelMap[r*SS+c]);
      return n;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pushWriteOut();
      exp_t e;
      for (int k = 0; k < SS; k++) begin
         e.cnt = AW'(k);
         e.row = modelMap[k*SS +: SS];
         e.rf  = (rowPop(k) >= ROW_TH);
         e.cf  = (colPop(k) >= COL_TH);
         sbq.push_back(e);
      end
   endtask

   task automatic applyStart();
      test_start = 1'b1;
      tick();
      test_start = 1'b0;
      modelMap = '0;
   endtask

   task automatic applyVector(input logic [SS*SS-1:0] v);
      compare_valid = 1'b1;
      pe_fail_flat  = v;
      tick();
      compare_valid = 1'b0;
      pe_fail_flat  = '0;
      modelMap      = modelMap | v;
   endtask

   task automatic applyDone(input logic [SS*SS-1:0] v, input logic withValid);
      test_done     = 1'b1;
      compare_valid = withValid;
      pe_fail_flat  = withValid ? v : '0;
      if (withValid) modelMap = modelMap | v;
      pushWriteOut();
      tick();
      test_done     = 1'b0;
      compare_valid = 1'b0;
      pe_fail_flat  = '0;
   endtask

   // Scoreboard monitor: every write-enabled cycle must match the next queued row.
   always @(negedge clk) begin
      if (detection_en === 1'b1) begin : mon
         exp_t e;
         checks = checks + 1;
         if (sbq.size() == 0) begin
            failures = failures + 1;
            $display("[TB] FAIL sb_unexpected_write counter=%0d expected no write", counter);
         end else begin
            e = sbq.pop_front();
            if ({counter, single_pe_detection, row_fault_detection, column_fault_detection} !== e) begin
               failures = failures + 1;
               $display("[TB] FAIL sb_row got cnt=%0d row=%h rf=%b cf=%b expected cnt=%0d row=%h rf=%b cf=%b",
                        counter, single_pe_detection, row_fault_detection, column_fault_detection,
                        e.cnt, e.row, e.rf, e.cf);
            end
         end
      end
   end

   task automatic test_reset_idle();
      rst = 1'b1;
      #2;
      checks++;
      if ({detection_en, counter, busy, done, single_pe_detection} !== '0) begin
         failures++;
         $display("[TB] FAIL reset_values got en=%b cnt=%0d busy=%b done=%b map=%h expected all 0",
                  detection_en, counter, busy, done, single_pe_detection);
      end
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         checks++;
         if ({detection_en, counter, done, single_pe_detection} !== '0) begin
            failures++;
            $display("[TB] FAIL idle_quiet cycle=%0d got en=%b cnt=%0d done=%b map=%h expected all 0",
                     i, detection_en, counter, done, single_pe_detection);
         end
         tick();
      end
      test_done = 1'b1;
      tick();
      test_done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if ({detection_en, busy} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL idle_ignores_done cycle=%0d got en=%b busy=%b expected 0 0",
                     i, detection_en, busy);
         end
         tick();
      end
   endtask

   task automatic test_single_fault();
      applyStart();
      applyVector(64'd1 << (3*SS+5));
      applyDone('0, 1'b0);
      for (int k = 0; k < SS; k++) begin
         checks++;
         if (detection_en !== 1'b1 || counter !== AW'(k)) begin
            failures++;
            $display("[TB] FAIL single_latency k=%0d got en=%b cnt=%0d expected 1 %0d", k, detection_en, counter, k);
         end
         if (k == 3) begin
            checks++;
            if (single_pe_detection !== 8'h20) begin
               failures++;
               $display("[TB] FAIL single_row3 got %h expected 20", single_pe_detection);
            end
         end
         checks++;
         if ({row_fault_detection, column_fault_detection} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL single_class k=%0d got rf=%b cf=%b expected 0 0",
                     k, row_fault_detection, column_fault_detection);
         end
         tick();
      end
      checks++;
      if ({done, detection_en} !== 2'b10) begin
         failures++;
         $display("[TB] FAIL single_done got done=%b en=%b expected 1 0", done, detection_en);
      end
      tick();
      checks++;
      if ({done, busy, sbq.size() == 0} !== 3'b001) begin
         failures++;
         $display("[TB] FAIL single_after got done=%b busy=%b pending=%0d expected 0 0 0", done, busy, sbq.size());
      end
   endtask

   task automatic test_sticky_thresholds();
      applyStart();
      applyVector(64'd1 << (2*SS+1));
      applyVector(64'd1 << (2*SS+6));
      applyVector(64'd1 << (5*SS+1));
      applyDone('0, 1'b0);
`ifdef FAULT_COUNT_EN
      checks++;
      if (total_fault_count !== 7'd3) begin
         failures++;
         $display("[TB] FAIL sticky_total got %0d expected 3", total_fault_count);
      end
`endif
      for (int k = 0; k < SS; k++) begin
         if (k == 1) begin
            checks++;
            if (column_fault_detection !== 1'b1) begin
               failures++;
               $display("[TB] FAIL sticky_col1 got %b expected 1", column_fault_detection);
            end
         end
         if (k == 2) begin
            checks++;
            if ({single_pe_detection, row_fault_detection} !== {8'h42, 1'b1}) begin
               failures++;
               $display("[TB] FAIL sticky_row2 got row=%h rf=%b expected 42 1", single_pe_detection, row_fault_detection);
            end
         end
         if (k == 5) begin
            checks++;
            if (row_fault_detection !== 1'b0) begin
               failures++;
               $display("[TB] FAIL sticky_row5 got %b expected 0", row_fault_detection);
            end
         end
         if (k == 6) begin
            checks++;
            if (column_fault_detection !== 1'b0) begin
               failures++;
               $display("[TB] FAIL sticky_col6 got %b expected 0", column_fault_detection);
            end
         end
         tick();
      end
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("[TB] FAIL sticky_done got %b expected 1", done);
      end
      tick();
   endtask

   task automatic test_simultaneous();
      applyStart();
      applyDone(64'd1 << 63, 1'b1);
      for (int k = 0; k < SS; k++) begin
         if (k == 7) begin
            checks++;
            if ({counter, single_pe_detection} !== {3'd7, 8'h80}) begin
               failures++;
               $display("[TB] FAIL simul_row7 got cnt=%0d row=%h expected 7 80", counter, single_pe_detection);
            end
         end
         tick();
      end
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("[TB] FAIL simul_done got %b expected 1", done);
      end
      tick();
   endtask

   task automatic test_abort();
      logic found = 1'b0;
      logic sawDone = 1'b0;
      applyStart();
      applyVector((64'd1 << (4*SS)) | (64'd1 << (4*SS+3)));
      applyDone('0, 1'b0);
      for (int i = 0; i < 12 && !found; i++) begin
         if (detection_en === 1'b1 && counter === 3'd4) found = 1'b1;
         else tick();
      end
      checks++;
      if (!found) begin
         failures++;
         $display("[TB] FAIL abort_reach4 got no counter=4 within 12 cycles expected it");
      end
      test_start = 1'b1;
      tick();
      test_start = 1'b0;
      sbq.delete();
      modelMap = '0;
      checks++;
      if ({detection_en, busy, done, single_pe_detection} !== {3'b010, 8'h00}) begin
         failures++;
         $display("[TB] FAIL abort_state got en=%b busy=%b done=%b map=%h expected 0 1 0 00",
                  detection_en, busy, done, single_pe_detection);
      end
`ifdef FAULT_COUNT_EN
      checks++;
      if (total_fault_count !== 7'd0) begin
         failures++;
         $display("[TB] FAIL abort_total got %0d expected 0", total_fault_count);
      end
`endif
      for (int i = 0; i < 8; i++) begin
         if (done === 1'b1) sawDone = 1'b1;
         tick();
      end
      checks++;
      if (sawDone !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL abort_no_done got sawDone=%b busy=%b expected 0 1", sawDone, busy);
      end
      applyVector(64'd1);
      applyDone('0, 1'b0);
      for (int k = 0; k < SS; k++) begin
         checks++;
         if (detection_en !== 1'b1 || counter !== AW'(k)) begin
            failures++;
            $display("[TB] FAIL abort_resume k=%0d got en=%b cnt=%0d expected 1 %0d", k, detection_en, counter, k);
         end
         tick();
      end
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("[TB] FAIL abort_resume_done got %b expected 1", done);
      end
      tick();
   endtask

   task automatic test_async_reset();
      logic found = 1'b0;
      logic sawBad = 1'b0;
      applyStart();
      applyVector(64'd1 << (5*SS+2));
      applyDone('0, 1'b0);
      for (int i = 0; i < 12 && !found; i++) begin
         if (detection_en === 1'b1 && counter === 3'd5) found = 1'b1;
         else tick();
      end
      checks++;
      if (!found) begin
         failures++;
         $display("[TB] FAIL areset_reach5 got no counter=5 within 12 cycles expected it");
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({detection_en, counter, busy, done} !== '0) begin
         failures++;
         $display("[TB] FAIL areset_immediate got en=%b cnt=%0d busy=%b done=%b expected all 0",
                  detection_en, counter, busy, done);
      end
      sbq.delete();
      modelMap = '0;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (done === 1'b1 || detection_en === 1'b1) sawBad = 1'b1;
         tick();
      end
      checks++;
      if ({sawBad, single_pe_detection, row_fault_detection} !== '0) begin
         failures++;
         $display("[TB] FAIL areset_after got sawDoneOrWrite=%b map=%h rf=%b expected 0 00 0",
                  sawBad, single_pe_detection, row_fault_detection);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got timeout expected bench completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset_idle();
      test_single_fault();
      test_sticky_thresholds();
      test_simultaneous();
      test_abort();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fault_map_collector.md
Name: fault_map_collector

Overview:
- Sits directly upstream of the eNVM fault store, between the systolic-array result comparator and the eNVM.
- Accumulates per-PE mismatch flags over all SA/TD test patterns of one test session into an SYSTOLIC_SIZE×SYSTOLIC_SIZE fault map.
- Classifies each row and column as faulty by threshold.
- Streams the map row by row into the eNVM write port (detection_en, counter, single_pe_detection, row/column fault bits).

Parameters:
- SYSTOLIC_SIZE, 8, array dimension (rows = columns).
- ADDR_WIDTH, $clog2(SYSTOLIC_SIZE), width of the row/column index.
- ROW_THRESHOLD, 2, a row is faulty when its faulty-PE count ≥ this value; legal range 1..SYSTOLIC_SIZE.
- COL_THRESHOLD, 2, a column is faulty when its faulty-PE count ≥ this value; legal range 1..SYSTOLIC_SIZE.
- CNT_WIDTH, $clog2(SYSTOLIC_SIZE*SYSTOLIC_SIZE+1), width of the total fault count.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- test_start  input  1  one-cycle pulse: clear the map and begin a session.
- compare_valid  input  1  pe_fail_flat is valid this cycle.
- pe_fail_flat  input  SYSTOLIC_SIZE*SYSTOLIC_SIZE  mismatch flags; bit r*SYSTOLIC_SIZE+c = PE(row r, col c).
- test_done  input  1  one-cycle pulse: all patterns applied, begin write-out.
- detection_en  output  1  eNVM write enable.
- counter  output  ADDR_WIDTH  row/column index being written.
- single_pe_detection  output  SYSTOLIC_SIZE  fault map row [counter]; bit c = PE(counter, c).
- row_fault_detection  output  1  row [counter] classified faulty.
- column_fault_detection  output  1  column [counter] classified faulty.
- busy  output  1  high in COLLECT or WRITE.
- done  output  1  one-cycle pulse when write-out completes.
- total_fault_count  output  CNT_WIDTH  present only with FAULT_COUNT_EN.

Behaviour:
- Reset (async, rst=1): state IDLE, map all 0, row pointer 0. detection_en=0, counter=0, busy=0, done=0. single_pe_detection, row_fault_detection and column_fault_detection read the cleared map (all 0).
- State IDLE:
  - test_start → COLLECT, map cleared on the same edge.
  - test_done and compare_valid are ignored.
- State COLLECT:
  - Each edge with compare_valid=1: map <= map | pe_fail_flat (sticky OR).
  - test_done → WRITE, pointer <= 0.
  - compare_valid together with test_done: that vector is merged before write-out begins.
  - test_start in COLLECT: map cleared, stays in COLLECT; test_start has priority over compare_valid.
- State WRITE:
  - detection_en=1. counter=pointer. Pointer increments every cycle.
  - When the pointer reaches SYSTOLIC_SIZE-1: → DONE.
  - compare_valid and test_done are ignored.
  - test_start aborts: detection_en drops on the next cycle, map cleared, → COLLECT, no done pulse.
- State DONE: done=1 for exactly one cycle, then → IDLE. The map is held until the next test_start.
- Latency: test_done sampled at edge t → detection_en high for cycles t+1..t+SYSTOLIC_SIZE with counter 0..SYSTOLIC_SIZE-1 → done high at cycle t+SYSTOLIC_SIZE+1.
- Output timing: detection_en, counter, busy and done decode only from state/pointer registers (Moore). The eNVM captures on the same rising edge.
- Classification:
  - row_fault_detection = popcount(map row[counter]) ≥ ROW_THRESHOLD.
  - column_fault_detection = popcount(map column[counter]) ≥ COL_THRESHOLD.
  - Both are combinational from the map and the pointer.
- Reset mid-session: everything returns to reset values immediately; no partial write completes.

Optional Feature:
- Macro FAULT_COUNT_EN.
- Defined:
  - Adds output total_fault_count = popcount of the whole map.
  - Registered; updated on the edge after each map change.
  - Cleared by rst and test_start.
  - Maximum value is SYSTOLIC_SIZE², which CNT_WIDTH holds without overflow.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: rst pulse, no stimulus → detection_en=0, counter=0, done=0, single_pe_detection=8'h00 for 20 cycles; test_done alone in IDLE → no write-out.
- Single fault:
  - Stimulus: test_start; one compare_valid with bit 3*8+5 set; test_done.
  - Write-out: 8 cycles of detection_en, counters 0..7.
  - Row 3: single_pe_detection=8'h20 at counter=3.
  - All row/column fault bits 0 (threshold 2).
  - done one cycle after counter=7.
- Sticky accumulate and thresholds:
  - Stimulus: three vectors setting PE(2,1), PE(2,6), PE(5,1).
  - counter=2: row_fault_detection=1, single_pe_detection=8'h42.
  - counter=1: column_fault_detection=1.
  - Row 5 fault 0; column 6 fault 0.
  - FAULT_COUNT_EN: total_fault_count=3.
- Simultaneous compare_valid and test_done: vector with PE(7,7) on the test_done cycle → counter=7 shows single_pe_detection=8'h80.
- Abort:
  - Stimulus: test_start asserted while counter=4 in WRITE.
  - Next cycle: detection_en=0, busy=1, no done; map reads all 0.
  - New session completes normally.
- Async reset mid-WRITE: rst asserted between edges at counter=5 → detection_en=0 and counter=0 immediately (before next edge), done never pulses.
